// File: rtl/ddr3_user_arbiter_pkg.sv
// rtl/ddr3_user_arbiter_pkg.sv - shared types, widths and round-robin pick for the DDR3 user arbiter
package ddr3_arbiter_pkg;

  localparam int DEF_NUM_REQ               = 4;
  localparam int DEF_ADDRESS_BITWIDTH      = 15;
  localparam int DEF_BANK_ADDRESS_BITWIDTH = 3;
  localparam int DEF_DQ_BITWIDTH           = 16;
  localparam int DEF_MAX_OUTSTANDING       = 4;

  localparam int USER_ADDR_W = DEF_BANK_ADDRESS_BITWIDTH + DEF_ADDRESS_BITWIDTH;
  localparam int TAG_W       = $clog2(DEF_NUM_REQ);

  // Widest requester vector the pick function handles
  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Returns {found, index}: first set bit of elig scanning ptr, ptr+1, ... mod n.
  // Scanned from the far end so the nearest offset is the last (winning) write.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] elig,
                                         input logic [2:0] ptr,
                                         input int n);
    logic [3:0] r;
    logic [2:0] sel;
    int         idx;
    r = 4'd0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        sel = 3'(idx);
        if (elig[sel]) r = {1'b1, sel};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr3_user_arbiter_if.sv
// rtl/ddr3_user_arbiter_if.sv - requester and controller-side bus of the DDR3 user arbiter
interface ddr3_user_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int UAW     = 18,
  parameter int DQ      = 16
);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_write;
  logic [NUM_REQ*UAW-1:0] req_addr;
  logic [NUM_REQ*DQ-1:0]  req_wdata;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [DQ-1:0]          rsp_rdata;
  logic                   ctrl_write_enable;
  logic                   ctrl_read_enable;
  logic [UAW-1:0]         ctrl_address;
  logic [DQ-1:0]          ctrl_wdata;
  logic                   ctrl_ready;
  logic [DQ-1:0]          ctrl_rdata;
  logic                   ctrl_rdata_valid;
  logic                   err_unexpected_rdata;

  // Arbiter side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  ctrl_ready, ctrl_rdata, ctrl_rdata_valid,
    output req_ready, rsp_valid, rsp_rdata,
    output ctrl_write_enable, ctrl_read_enable, ctrl_address, ctrl_wdata,
    output err_unexpected_rdata
  );

  // Requesters plus controller, as seen from outside the arbiter
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output ctrl_ready, ctrl_rdata, ctrl_rdata_valid,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ctrl_write_enable, ctrl_read_enable, ctrl_address, ctrl_wdata,
    input  err_unexpected_rdata
  );

endinterface

// File: rtl/ddr3_user_arbiter_tag_fifo.sv
// rtl/ddr3_user_arbiter_tag_fifo.sv - in-order FIFO of requester tags for reads in flight
module ddr3_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Tag storage; contents are don't-care while the slot is free
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally; count covers 0..DEPTH inclusive
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_user_arbiter.sv
// rtl/ddr3_user_arbiter.sv - round-robin sharing of the DDR3 controller user port
module ddr3_user_arbiter
  import ddr3_arbiter_pkg::*;
#(
  parameter int NUM_REQ               = DEF_NUM_REQ,
  parameter int ADDRESS_BITWIDTH      = DEF_ADDRESS_BITWIDTH,
  parameter int BANK_ADDRESS_BITWIDTH = DEF_BANK_ADDRESS_BITWIDTH,
  parameter int DQ_BITWIDTH           = DEF_DQ_BITWIDTH,
  parameter int MAX_OUTSTANDING       = DEF_MAX_OUTSTANDING
) (
  input logic                clk,
  input logic                resetn,
  ddr3_user_arbiter_if.slave bus
);

  localparam int UAW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int TW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;

  state_t               r_state;
  logic [2:0]           r_rr_ptr;
  logic [2:0]           r_grant;
  logic                 r_wr_en;
  logic                 r_rd_en;
  logic [UAW-1:0]       r_addr;
  logic [DQ_BITWIDTH-1:0] r_wdata;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DQ_BITWIDTH-1:0] r_rsp_rdata;
  logic                 r_err;

  logic [CW-1:0]        w_count;
  logic                 w_full;
  logic                 w_empty;
  logic [TW-1:0]        w_head;
  logic                 w_pending;
  logic [CW:0]          w_inflight;
  logic                 w_read_ok;
  logic [MAX_REQ-1:0]   w_elig;
  logic [3:0]           w_pick;
  logic                 w_take;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [2:0]           w_next_ptr;
  logic [NUM_REQ-1:0]   w_ready;
  logic [UAW-1:0]       w_sel_addr;
  logic [DQ_BITWIDTH-1:0] w_sel_wdata;
  logic                 w_sel_write;

  // A read sitting in ISSUE already owns a slot even though it is not yet pushed
  assign w_pending  = (r_state == ISSUE) && r_rd_en;
  assign w_inflight = {1'b0, w_count} + {{CW{1'b0}}, w_pending};
  assign w_read_ok  = !w_full && (w_inflight < (CW+1)'(MAX_OUTSTANDING));
  assign w_pick     = rr_pick(w_elig, r_rr_ptr, NUM_REQ);
  assign w_take     = resetn && (r_state == IDLE) && w_pick[3];
  assign w_accept   = (r_state == ISSUE) && bus.ctrl_ready;
  assign w_push     = w_accept && r_rd_en;
  assign w_pop      = bus.ctrl_rdata_valid && !w_empty;
  assign w_next_ptr = (r_grant == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant + 3'd1;

  // Eligibility, grant pulse and the winner's command mux
  always_comb begin
    w_elig      = '0;
    w_ready     = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i]  = bus.req_valid[i] && (bus.req_write[i] || w_read_ok);
      w_ready[i] = w_take && (w_pick[2:0] == 3'(i));
      if (w_pick[2:0] == 3'(i)) begin
        w_sel_addr  = bus.req_addr[i*UAW +: UAW];
        w_sel_wdata = bus.req_wdata[i*DQ_BITWIDTH +: DQ_BITWIDTH];
        w_sel_write = bus.req_write[i];
      end
    end
  end

  ddr3_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (TW)
  ) u_tag_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_push),
    .i_push_data (r_grant[TW-1:0]),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // Grant/issue FSM: latch the winner, hold it until the controller takes it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick[3]) begin
            r_grant <= w_pick[2:0];
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_wr_en <= w_sel_write;
            r_rd_en <= !w_sel_write;
            r_state <= ISSUE;
          end
        end
        default: begin
          if (bus.ctrl_ready) begin
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= IDLE;
          end
        end
      endcase
    end
  end

  // Route returning read data to the oldest tag; orphan data only raises the flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_pop) begin
        for (int i = 0; i < NUM_REQ; i++) r_rsp_valid[i] <= (w_head == TW'(i));
        r_rsp_rdata <= bus.ctrl_rdata;
      end else if (bus.ctrl_rdata_valid) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.req_ready            = w_ready;
  assign bus.rsp_valid            = r_rsp_valid;
  assign bus.rsp_rdata            = r_rsp_rdata;
  assign bus.ctrl_write_enable    = r_wr_en;
  assign bus.ctrl_read_enable     = r_rd_en;
  assign bus.ctrl_address         = r_addr;
  assign bus.ctrl_wdata           = r_wdata;
  assign bus.err_unexpected_rdata = r_err;

endmodule

// File: tb/tb_ddr3_user_arbiter.sv
// tb/tb_ddr3_user_arbiter.sv - directed self-checking bench for the DDR3 user arbiter
module tb_ddr3_user_arbiter;

  localparam int NR  = 4;
  localparam int UAW = 18;
  localparam int DQ  = 16;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  ddr3_user_arbiter_if #(.NUM_REQ(NR), .UAW(UAW), .DQ(DQ)) bus_if ();

  ddr3_user_arbiter #(
    .NUM_REQ               (NR),
    .ADDRESS_BITWIDTH      (15),
    .BANK_ADDRESS_BITWIDTH (3),
    .DQ_BITWIDTH           (DQ),
    .MAX_OUTSTANDING       (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic w, input logic [UAW-1:0] a, input logic [DQ-1:0] d);
    bus_if.req_write[i]           = w;
    bus_if.req_addr[i*UAW +: UAW] = a;
    bus_if.req_wdata[i*DQ +: DQ]  = d;
  endtask

  task automatic clear_inputs();
    bus_if.req_valid        = '0;
    bus_if.req_write        = '0;
    bus_if.req_addr         = '0;
    bus_if.req_wdata        = '0;
    bus_if.ctrl_ready       = 1'b0;
    bus_if.ctrl_rdata       = '0;
    bus_if.ctrl_rdata_valid = 1'b0;
  endtask

  // Leaves the caller at a negedge with resetn just released
  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Called right after driving at a negedge; stops at the first cycle with a grant
  task automatic wait_ready(input int budget, output logic [NR-1:0] mask, output bit to);
    mask = '0;
    to   = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bus_if.req_ready != '0) begin
        mask = bus_if.req_ready;
        to   = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    bus_if.req_valid        = 4'b1111;
    bus_if.req_write        = 4'b1111;
    bus_if.ctrl_rdata_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus_if.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus_if.req_ready); end
    checks++;
    if ({bus_if.ctrl_write_enable, bus_if.ctrl_read_enable} !== 2'b00) begin errors++; $display("FAIL reset_enables: got %b want 00", {bus_if.ctrl_write_enable, bus_if.ctrl_read_enable}); end
    checks++;
    if ({bus_if.ctrl_address, bus_if.ctrl_wdata} !== 34'h0) begin errors++; $display("FAIL reset_ctrl_bus: got %h want 0", {bus_if.ctrl_address, bus_if.ctrl_wdata}); end
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_rdata} !== 20'h0) begin errors++; $display("FAIL reset_rsp: got %h want 0", {bus_if.rsp_valid, bus_if.rsp_rdata}); end
    checks++;
    if (bus_if.err_unexpected_rdata !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_if.err_unexpected_rdata); end
    clear_inputs();
  endtask

  task automatic test_single_write();
    do_reset();
    bus_if.ctrl_ready = 1'b1;
    set_req(1, 1'b1, 18'h00123, 16'hBEEF);
    bus_if.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus_if.req_ready !== 4'b0010) begin errors++; $display("FAIL wr_grant: got %b want 0010", bus_if.req_ready); end
    @(negedge clk);
    bus_if.req_valid = '0;
    #1;
    checks++;
    if ({bus_if.ctrl_write_enable, bus_if.ctrl_read_enable} !== 2'b10) begin errors++; $display("FAIL wr_enables: got %b want 10", {bus_if.ctrl_write_enable, bus_if.ctrl_read_enable}); end
    checks++;
    if (bus_if.ctrl_address !== 18'h00123) begin errors++; $display("FAIL wr_addr: got %h want 00123", bus_if.ctrl_address); end
    checks++;
    if (bus_if.ctrl_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_data: got %h want beef", bus_if.ctrl_wdata); end
    @(negedge clk);
    #1;
    checks++;
    if (bus_if.ctrl_write_enable !== 1'b0) begin errors++; $display("FAIL wr_one_cycle: got %b want 0", bus_if.ctrl_write_enable); end
  endtask

  task automatic test_round_robin();
    int            grant_n;
    int            acc_n;
    int            rsp_n;
    int            ret_cyc[$];
    logic [DQ-1:0] ret_dat[$];
    logic [NR-1:0] exp_mask;
    grant_n = 0;
    acc_n   = 0;
    rsp_n   = 0;
    do_reset();
    bus_if.ctrl_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 18'h00100 + 18'(i), 16'h0);
    bus_if.req_valid = 4'b1111;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        bus_if.ctrl_rdata_valid = 1'b0;
        if (ret_cyc.size() > 0 && ret_cyc[0] == cyc) begin
          bus_if.ctrl_rdata_valid = 1'b1;
          bus_if.ctrl_rdata       = ret_dat.pop_front();
          void'(ret_cyc.pop_front());
        end
        if (grant_n >= 8) bus_if.req_valid = '0;
      end
      #1;
      if (bus_if.req_ready != '0) begin
        exp_mask = NR'(1) << (grant_n % NR);
        checks++;
        if (bus_if.req_ready !== exp_mask) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", grant_n, bus_if.req_ready, exp_mask); end
        grant_n++;
      end
      if (bus_if.ctrl_read_enable && bus_if.ctrl_ready) begin
        checks++;
        if (bus_if.ctrl_address !== 18'h00100 + 18'(acc_n % NR)) begin errors++; $display("FAIL rr_addr_%0d: got %h want %h", acc_n, bus_if.ctrl_address, 18'h00100 + 18'(acc_n % NR)); end
        ret_cyc.push_back(cyc + 3);
        ret_dat.push_back(16'hC000 + 16'(acc_n));
        acc_n++;
      end
      if (bus_if.rsp_valid != '0) begin
        exp_mask = NR'(1) << (rsp_n % NR);
        checks++;
        if ({bus_if.rsp_valid, bus_if.rsp_rdata} !== {exp_mask, 16'hC000 + 16'(rsp_n)}) begin
          errors++;
          $display("FAIL rr_rsp_%0d: got %b/%h want %b/%h", rsp_n, bus_if.rsp_valid, bus_if.rsp_rdata, exp_mask, 16'hC000 + 16'(rsp_n));
        end
        rsp_n++;
      end
    end
    checks++;
    if ({grant_n, acc_n, rsp_n} !== {32'd8, 32'd8, 32'd8}) begin errors++; $display("FAIL rr_counts: got %0d/%0d/%0d want 8/8/8", grant_n, acc_n, rsp_n); end
    clear_inputs();
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_req(0, 1'b1, 18'h2A5A5, 16'h1357);
    set_req(2, 1'b0, 18'h00777, 16'h0);
    bus_if.req_valid = 4'b0101;
    #1;
    checks++;
    if (bus_if.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant: got %b want 0001", bus_if.req_ready); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus_if.ctrl_write_enable, bus_if.ctrl_read_enable, bus_if.ctrl_address, bus_if.ctrl_wdata} !== {2'b10, 18'h2A5A5, 16'h1357}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got %b%b/%h/%h want 10/2a5a5/1357", k, bus_if.ctrl_write_enable, bus_if.ctrl_read_enable, bus_if.ctrl_address, bus_if.ctrl_wdata);
      end
      checks++;
      if (bus_if.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_grant_%0d: got %b want 0000", k, bus_if.req_ready); end
    end
    @(negedge clk);
    bus_if.ctrl_ready = 1'b1;
    #1;
    checks++;
    if (bus_if.ctrl_write_enable !== 1'b1) begin errors++; $display("FAIL bp_present: got %b want 1", bus_if.ctrl_write_enable); end
    @(negedge clk);
    #1;
    checks++;
    if ({bus_if.ctrl_write_enable, bus_if.req_ready} !== {1'b0, 4'b0100}) begin errors++; $display("FAIL bp_next_grant: got %b/%b want 0/0100", bus_if.ctrl_write_enable, bus_if.req_ready); end
    @(negedge clk);
    bus_if.req_valid = '0;
    #1;
    checks++;
    if ({bus_if.ctrl_read_enable, bus_if.ctrl_address} !== {1'b1, 18'h00777}) begin errors++; $display("FAIL bp_read_issue: got %b/%h want 1/00777", bus_if.ctrl_read_enable, bus_if.ctrl_address); end
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    logic [NR-1:0] m;
    bit            to;
    do_reset();
    bus_if.ctrl_ready = 1'b1;
    set_req(0, 1'b0, 18'h00010, 16'h0);
    set_req(1, 1'b0, 18'h00011, 16'h0);
    bus_if.req_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      wait_ready(6, m, to);
      checks++;
      if (to || m !== ((k % 2 == 0) ? 4'b0001 : 4'b0010)) begin errors++; $display("FAIL ff_fill_%0d: got %b timeout=%0d want %b", k, m, to, (k % 2 == 0) ? 4'b0001 : 4'b0010); end
    end
    @(negedge clk);
    set_req(2, 1'b0, 18'h00022, 16'h0);
    set_req(3, 1'b1, 18'h00033, 16'h3333);
    bus_if.req_valid = 4'b1100;
    wait_ready(6, m, to);
    checks++;
    if (to || m !== 4'b1000) begin errors++; $display("FAIL ff_write_wins: got %b timeout=%0d want 1000", m, to); end
    @(negedge clk);
    bus_if.req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if ({bus_if.req_ready, bus_if.rsp_valid} !== 8'h00) begin errors++; $display("FAIL ff_blocked_%0d: got ready=%b rsp=%b want 0000/0000", k, bus_if.req_ready, bus_if.rsp_valid); end
    end
    @(negedge clk);
    bus_if.ctrl_rdata_valid = 1'b1;
    bus_if.ctrl_rdata       = 16'h1234;
    #1;
    checks++;
    if (bus_if.req_ready !== 4'b0000) begin errors++; $display("FAIL ff_no_same_cycle: got %b want 0000", bus_if.req_ready); end
    @(negedge clk);
    bus_if.ctrl_rdata_valid = 1'b0;
    #1;
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_rdata} !== {4'b0001, 16'h1234}) begin errors++; $display("FAIL ff_rsp: got %b/%h want 0001/1234", bus_if.rsp_valid, bus_if.rsp_rdata); end
    checks++;
    if (bus_if.req_ready !== 4'b0100) begin errors++; $display("FAIL ff_read_unblocked: got %b want 0100", bus_if.req_ready); end
    @(negedge clk);
    bus_if.req_valid = '0;
    #1;
    checks++;
    if ({bus_if.ctrl_read_enable, bus_if.ctrl_address} !== {1'b1, 18'h00022}) begin errors++; $display("FAIL ff_read_issue: got %b/%h want 1/00022", bus_if.ctrl_read_enable, bus_if.ctrl_address); end
    clear_inputs();
  endtask

  task automatic test_unexpected_rdata();
    do_reset();
    bus_if.ctrl_rdata_valid = 1'b1;
    bus_if.ctrl_rdata       = 16'h5555;
    #1;
    checks++;
    if (bus_if.err_unexpected_rdata !== 1'b0) begin errors++; $display("FAIL ue_before: got %b want 0", bus_if.err_unexpected_rdata); end
    @(negedge clk);
    bus_if.ctrl_rdata_valid = 1'b0;
    #1;
    checks++;
    if ({bus_if.rsp_valid, bus_if.err_unexpected_rdata} !== {4'b0000, 1'b1}) begin errors++; $display("FAIL ue_flag: got rsp=%b err=%b want 0000/1", bus_if.rsp_valid, bus_if.err_unexpected_rdata); end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (bus_if.err_unexpected_rdata !== 1'b1) begin errors++; $display("FAIL ue_sticky: got %b want 1", bus_if.err_unexpected_rdata); end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus_if.err_unexpected_rdata !== 1'b0) begin errors++; $display("FAIL ue_cleared: got %b want 0", bus_if.err_unexpected_rdata); end
    resetn = 1'b1;
  endtask

  task automatic test_reset_mid_issue();
    logic [NR-1:0] m;
    bit            to;
    do_reset();
    bus_if.ctrl_ready = 1'b1;
    set_req(0, 1'b0, 18'h00040, 16'h0);
    set_req(1, 1'b0, 18'h00041, 16'h0);
    bus_if.req_valid = 4'b0011;
    wait_ready(6, m, to);
    @(negedge clk);
    wait_ready(6, m, to);
    checks++;
    if (to || m !== 4'b0010) begin errors++; $display("FAIL mid_second_read: got %b timeout=%0d want 0010", m, to); end
    @(negedge clk);
    bus_if.req_valid = '0;
    @(negedge clk);
    bus_if.ctrl_ready = 1'b0;
    set_req(2, 1'b1, 18'h00042, 16'h4242);
    bus_if.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus_if.req_ready !== 4'b0100) begin errors++; $display("FAIL mid_write_grant: got %b want 0100", bus_if.req_ready); end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.ctrl_write_enable, bus_if.ctrl_read_enable, bus_if.err_unexpected_rdata} !== 11'h0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got ready=%b rsp=%b we=%b re=%b err=%b want all 0", bus_if.req_ready, bus_if.rsp_valid, bus_if.ctrl_write_enable, bus_if.ctrl_read_enable, bus_if.err_unexpected_rdata);
    end
    checks++;
    if ({bus_if.ctrl_address, bus_if.ctrl_wdata, bus_if.rsp_rdata} !== 50'h0) begin errors++; $display("FAIL mid_reset_data: got %h/%h/%h want 0", bus_if.ctrl_address, bus_if.ctrl_wdata, bus_if.rsp_rdata); end
    resetn = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 18'h00050 + 18'(i), 16'h0);
    bus_if.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus_if.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_ptr_zero: got %b want 0001", bus_if.req_ready); end
    @(negedge clk);
    bus_if.req_valid        = '0;
    bus_if.ctrl_ready       = 1'b1;
    bus_if.ctrl_rdata_valid = 1'b1;
    bus_if.ctrl_rdata       = 16'h7777;
    @(negedge clk);
    bus_if.ctrl_rdata_valid = 1'b0;
    #1;
    checks++;
    if ({bus_if.rsp_valid, bus_if.err_unexpected_rdata} !== {4'b0000, 1'b1}) begin errors++; $display("FAIL mid_fifo_empty: got rsp=%b err=%b want 0000/1", bus_if.rsp_valid, bus_if.err_unexpected_rdata); end
    clear_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_back_pressure();
    test_fifo_full();
    test_unexpected_rdata();
    test_reset_mid_issue();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
